bus_hold_arbiter: RTL
=====================

// Module: bus_hold_arbiter
// PURPOSE
//  Shares the V33 external bus between the CPU bus control unit and an external master via hldrq/hldak.
//  Inhibits new BCU cycles when a hold is pending; grants only at a bus-idle boundary and never inside a locked or intack sequence.
//  Floats the bus pins while held and drives n_buslock.
//  Sits between the BCU and the pin drivers; steps on ce_1 like the BCU T-states.
// PARAMETERS
//  SYNC_STAGES     2   hldrq synchroniser depth in clk flops (>=1)
//  MIN_CPU_CYCLES  2   BCU cycles guaranteed between holds (BUS_HOLD_MIN_CPU_EN only)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high
//  ce_1             in   1   phase-1 clock enable (state steps)
//  ce_2             in   1   phase-2 clock enable (pin-float update)
//  hldrq            in   1   external hold request pin, async
//  hldak            out  1   hold acknowledge pin
//  eu_buslock       in   1   EU lock prefix active
//  n_buslock        out  1   bus lock pin, active-low
//  bcu_idle         in   1   BCU in T_IDLE, no cycle in flight
//  bcu_intack_seq   in   1   BCU between INT_ACK1 and INT_ACK2
//  bcu_cycle_done   in   1   1-clk pulse: BCU T_2 completed with ready
//  bcu_inhibit      out  1   comb: BCU must not start T_1 at this ce_1
//  bus_float        out  1   tristate addr/data/status/strobe pins
//  hold_count       out  16  ce_1 ticks spent in last/current hold, saturating
// BEHAVIOUR
//  Reset: state=S_CPU, hldak=0, bus_float=0, hold_count=0, sync chain=0, credit=0.
//  Reset mid-hold: same; the external master sees hldak drop on the next clk.
//  hldrq_s = hldrq after SYNC_STAGES flops on every clk.
//  blocked = eu_buslock | bcu_intack_seq | (credit!=0).
//  n_buslock = ~(eu_buslock & state==S_CPU).
//  bcu_inhibit = (state!=S_CPU) | (hldrq_s & ~blocked). Comb, so the BCU sees it in the same ce_1.
//  FSM, transitions only on ce_1:
//   S_CPU: hldrq_s & ~blocked & bcu_idle -> S_GRANT; hold_count<=0.
//          With hldrq_s & ~blocked & ~bcu_idle, stay in S_CPU with inhibit asserted until idle.
//   S_GRANT: bus_float<=1 at the next ce_2.
//          At ce_1: hldrq_s -> S_HOLD, hldak<=1; else -> S_RELEASE with no hldak pulse (abort).
//   S_HOLD: hold_count+=1 per ce_1, saturating at 16'hFFFF.
//          ~hldrq_s -> S_RELEASE, hldak<=0.
//   S_RELEASE: bus_float<=0 at the next ce_2; at ce_1 -> S_CPU; credit loaded (option).
//  hldak always deasserts at least one ce_1 before bus_float clears.
//  bus_float always sets before hldak rises.
//  Priority: an eu_buslock rising while in S_CPU with a hold pending cancels the pending grant; the lock wins.
//  An eu_buslock that is already granted (S_GRANT/S_HOLD) is ignored until release.
//  Simultaneous hldrq rise and bcu_idle at the same ce_1 with sync latency not elapsed: CPU cycle proceeds; grant at its end.
//  ce_1 and ce_2 are never both high; the block does nothing when neither is set.
// CONFIGURATION
//  BUS_HOLD_MIN_CPU_EN defined:
//   - 4-bit credit loaded with MIN_CPU_CYCLES on S_RELEASE->S_CPU.
//   - credit decrements on bcu_cycle_done, saturating at 0; holds are blocked while credit!=0.
//  Undefined: credit tied 0; a hold can re-grant at the first idle ce_1 after release.
// STRUCTURE
//  types package: hold_state_e {S_CPU,S_GRANT,S_HOLD,S_RELEASE}; HOLD_COUNT_W=16.
//  Sub-module hold_sync: SYNC_STAGES-deep reset-to-0 synchroniser for hldrq.
//  Rest flat: FSM, counters, comb inhibit/n_buslock.
// TESTING
//  1. BCU idle, hldrq=1: inhibit in <=SYNC_STAGES clk; bus_float=1 one ce_2 later; hldak=1 at next ce_1.
//     hldrq=0 -> hldak=0 at next ce_1, bus_float=0 at following ce_2.
//  2. hldrq during an active MEM_READ (bcu_idle=0): no grant until bcu_idle=1; no T_1 started after the inhibit rises.
//  3. eu_buslock=1 with hldrq=1 for 20 ce_1: hldak stays 0, n_buslock=0.
//     Drop the lock -> grant follows on the next idle ce_1.
//  4. hldrq pulses for 1 ce_1 into S_GRANT: hldak never rises; state returns to S_CPU through S_RELEASE.
//     Hold 70000 ce_1 -> hold_count=16'hFFFF.
//  5. Reset during S_HOLD: hldak=0 and bus_float=0 one clk later; inhibit=0 with hldrq held low.
//  6. BUS_HOLD_MIN_CPU_EN, MIN_CPU_CYCLES=2: release followed by immediate hldrq -> re-grant only after 2 bcu_cycle_done pulses.

Source files
------------

// File: rtl/bus_hold_arbiter_pkg.sv
// Shared types and constants for the bus hold arbiter.
//   hold_state_e : arbiter FSM states
//   HOLD_COUNT_W : width of the hold duration counter
//   CREDIT_W     : width of the post-release CPU cycle credit
//   sat_inc      : saturating increment for the hold counter
package bus_hold_arbiter_pkg;

  localparam int unsigned HOLD_COUNT_W = 16;
  localparam int unsigned CREDIT_W     = 4;

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_GRANT   = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } hold_state_e;

  // Saturating +1; sticks at all-ones.
  function automatic logic [HOLD_COUNT_W-1:0] sat_inc(input logic [HOLD_COUNT_W-1:0] v);
    return (&v) ? v : v + HOLD_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/bus_hold_arbiter_hold_sync.sv
// hldrq synchroniser: SYNC_STAGES-deep flop chain, synchronously reset to 0.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   d     in  asynchronous input
//   q     out synchronised output (last stage)
module bus_hold_arbiter_hold_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input into stage 0; works for any depth >= 1.
  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bus_hold_arbiter.sv
// Bus hold arbiter: shares the external bus between the BCU and an external
// master via hldrq/hldak. Grants only at BCU idle boundaries, never inside a
// locked or interrupt-acknowledge sequence, and floats the bus pins while held.
// Optional feature macro: BUS_HOLD_MIN_CPU_EN (guaranteed BCU cycles between holds).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ce_1, ce_2        phase enables: ce_1 steps the FSM, ce_2 updates bus_float
//   hldrq / hldak     hold request (async) / acknowledge
//   eu_buslock        EU lock prefix active
//   n_buslock         bus lock pin, active-low (combinational)
//   bcu_idle          BCU idle, no cycle in flight
//   bcu_intack_seq    BCU inside INT_ACK1..INT_ACK2
//   bcu_cycle_done    1-clk pulse per completed BCU cycle
//   bcu_inhibit       combinational: BCU must not start T_1 this ce_1
//   bus_float         tristate the bus pins
//   hold_count        ce_1 ticks in last/current hold, saturating
module bus_hold_arbiter
  import bus_hold_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned MIN_CPU_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce_1,
  input  logic                    ce_2,
  input  logic                    hldrq,
  output logic                    hldak,
  input  logic                    eu_buslock,
  output logic                    n_buslock,
  input  logic                    bcu_idle,
  input  logic                    bcu_intack_seq,
  input  logic                    bcu_cycle_done,
  output logic                    bcu_inhibit,
  output logic                    bus_float,
  output logic [HOLD_COUNT_W-1:0] hold_count
);

`ifdef BUS_HOLD_MIN_CPU_EN
  localparam logic MIN_CPU_EN = 1'b1;
`else
  localparam logic MIN_CPU_EN = 1'b0;
`endif

  // Value loaded into the credit on release; zero keeps the credit tied off.
  localparam logic [CREDIT_W-1:0] CREDIT_LOAD =
    CREDIT_W'(MIN_CPU_CYCLES) & {CREDIT_W{MIN_CPU_EN}};

  hold_state_e             state_q, state_d;
  logic                    hldak_q, hldak_d;
  logic                    bus_float_q, bus_float_d;
  logic [HOLD_COUNT_W-1:0] hold_count_q, hold_count_d;
  logic [CREDIT_W-1:0]     credit_q, credit_d;

  logic hldrq_s;
  logic blocked;
  logic grant_req;

  bus_hold_arbiter_hold_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_hold_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hldrq),
    .q     (hldrq_s)
  );

  // Combinational qualifiers and BCU-facing outputs.
  always_comb begin
    blocked     = eu_buslock | bcu_intack_seq | (credit_q != '0);
    grant_req   = hldrq_s & ~blocked;
    bcu_inhibit = (state_q != S_CPU) | grant_req;
    n_buslock   = ~(eu_buslock & (state_q == S_CPU));
  end

  // Next-state: FSM steps on ce_1, pin float follows state on ce_2.
  always_comb begin
    state_d      = state_q;
    hldak_d      = hldak_q;
    bus_float_d  = bus_float_q;
    hold_count_d = hold_count_q;
    credit_d     = credit_q;

    if (ce_1) begin
      unique case (state_q)
        S_CPU: begin
          // A pending request waits here with inhibit set until the BCU idles.
          if (grant_req && bcu_idle) begin
            state_d      = S_GRANT;
            hold_count_d = '0;
          end
        end
        S_GRANT: begin
          // A request withdrawn before acknowledge aborts without an hldak pulse.
          if (hldrq_s) begin
            state_d = S_HOLD;
            hldak_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end
        S_HOLD: begin
          hold_count_d = sat_inc(hold_count_q);
          if (!hldrq_s) begin
            state_d = S_RELEASE;
            hldak_d = 1'b0;
          end
        end
        S_RELEASE: begin
          state_d = S_CPU;
        end
        default: begin
          state_d = S_CPU;
        end
      endcase
    end

    if (ce_2) begin
      bus_float_d = (state_q == S_GRANT) || (state_q == S_HOLD);
    end

    // Credit reloads on leaving release; otherwise counts down completed BCU cycles.
    if (ce_1 && (state_q == S_RELEASE)) begin
      credit_d = CREDIT_LOAD;
    end else if (bcu_cycle_done && (credit_q != '0)) begin
      credit_d = credit_q - CREDIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CPU;
      hldak_q      <= 1'b0;
      bus_float_q  <= 1'b0;
      hold_count_q <= '0;
      credit_q     <= '0;
    end else begin
      state_q      <= state_d;
      hldak_q      <= hldak_d;
      bus_float_q  <= bus_float_d;
      hold_count_q <= hold_count_d;
      credit_q     <= credit_d;
    end
  end

  assign hldak      = hldak_q;
  assign bus_float  = bus_float_q;
  assign hold_count = hold_count_q;

endmodule
